// File: rtl/alu_multicycle_cla.sv
// Multi-cycle ALU: WIDTH-bit operands processed one SLICE-bit carry-lookahead
// chunk per clock, LSB chunk first, with valid/ready handshakes on both sides.
`timescale 1ns/1ps
module alu_multicycle_cla #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_op,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             is_sub, init_carry, last, ovf_int;
  logic [SLICE-1:0] a_c, b_c, g, p, sum, chunk_res;
  logic [SLICE:0]   c;
  logic [WIDTH-1:0] res_ins, res_fin;
  logic             co_fin, ov_fin;

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);

  assign is_sub     = (op_q == 3'b100) || (op_q[2:1] == 2'b11);
  assign init_carry = (alu_op == 3'b100) || (alu_op[2:1] == 2'b11);
  assign last       = (cnt == CW'(N - 1));

  always_comb begin
    a_c  = a_q[cnt*SLICE +: SLICE];
    b_c  = b_q[cnt*SLICE +: SLICE] ^ {SLICE{is_sub}};
    g    = a_c & b_c;
    p    = a_c | b_c;
    c    = '0;
    c[0] = carry;
    for (int unsigned k = 0; k < SLICE; k++)
      c[k+1] = g[k] | (p[k] & c[k]);
    sum = a_c ^ b_c ^ c[SLICE-1:0];

    if (op_q[2]) chunk_res = sum;
    else begin
      case (op_q[1:0])
        2'b00:   chunk_res = a_c & b_c;
        2'b01:   chunk_res = a_c | b_c;
        2'b10:   chunk_res = a_c ^ b_c;
        default: chunk_res = ~(a_c | b_c);
      endcase
    end

    res_ins = result;
    res_ins[cnt*SLICE +: SLICE] = chunk_res;

    // Last-chunk fix-up: comparisons collapse to a single LSB.
    ovf_int = c[SLICE-1] ^ c[SLICE];
    res_fin = res_ins;
    if (op_q == 3'b110) begin
      res_fin    = '0;
      res_fin[0] = sum[SLICE-1] ^ ovf_int;
    end else if (op_q == 3'b111) begin
      res_fin    = '0;
      res_fin[0] = ~c[SLICE];
    end
    co_fin = op_q[2] & c[SLICE];
    ov_fin = (op_q[2:1] == 2'b10) & ovf_int;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= alu_op;
            cnt   <= '0;
            carry <= init_carry;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= c[SLICE];
          cnt   <= cnt + 1'b1;
          if (last) begin
            result    <= res_fin;
            carry_out <= co_fin;
            overflow  <= ov_fin;
            zero      <= (res_fin == '0);
            state     <= DONE;
          end else begin
            result <= res_ins;
          end
        end
        DONE: begin
          if (result_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle_cla.sv
// Directed-vector bench for alu_multicycle_cla at WIDTH=32 and WIDTH=8.
`timescale 1ns/1ps
module tb_alu_multicycle_cla;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        sv32 = 0, rr32 = 0, sr32, rv32, co32, ov32, zr32;
  logic [31:0] a32 = 0, b32 = 0, res32;
  logic [2:0]  op32 = 0;

  logic        sv8 = 0, rr8 = 0, sr8, rv8, co8, ov8, zr8;
  logic [7:0]  a8 = 0, b8 = 0, res8;
  logic [2:0]  op8 = 0;

  alu_multicycle_cla #(.WIDTH(32), .SLICE(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv32), .start_ready(sr32),
    .a(a32), .b(b32), .alu_op(op32), .result_valid(rv32), .result_ready(rr32),
    .result(res32), .carry_out(co32), .overflow(ov32), .zero(zr32)
  );

  alu_multicycle_cla #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .alu_op(op8), .result_valid(rv8), .result_ready(rr8),
    .result(res8), .carry_out(co8), .overflow(ov8), .zero(zr8)
  );

  task automatic start32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    sv32 = 1; op32 = op; a32 = a; b32 = b;
    @(posedge clk);
    #1;
    sv32 = 0; op32 = ~op; a32 = ~a; b32 = b ^ 32'h5A5A_A5A5;
  endtask

  task automatic wait32(output int lat);
    lat = 0;
    while (!rv32 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release32();
    @(negedge clk);
    rr32 = 1;
    @(posedge clk);
    #1;
    rr32 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    checks++;
    if ({sr32, rv32, res32, co32, ov32, zr32} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset32: got sr=%b rv=%b res=%h co=%b ov=%b z=%b expected sr=1 rv=0 res=0 co=0 ov=0 z=0",
               sr32, rv32, res32, co32, ov32, zr32);
    end
    checks++;
    if ({sr8, rv8, res8, co8, ov8, zr8} !== {1'b1, 1'b0, 8'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset8: got sr=%b rv=%b res=%h co=%b ov=%b z=%b expected sr=1 rv=0 res=0 co=0 ov=0 z=0",
               sr8, rv8, res8, co8, ov8, zr8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        co, ov, z;
  } vec_t;

  task automatic test_alu_ops();
    vec_t v[10];
    int lat;
    v[0] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 1};
    v[1] = '{3'b100, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1, 1, 0};
    v[2] = '{3'b101, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0};
    v[3] = '{3'b110, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1, 0, 0};
    v[4] = '{3'b111, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000, 1, 0, 1};
    v[5] = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 0, 1};
    v[6] = '{3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 0};
    v[7] = '{3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 0, 0, 0};
    v[8] = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0};
    v[9] = '{3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      start32(v[i].op, v[i].a, v[i].b);
      wait32(lat);
      checks++;
      if (lat != 8) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d cycles expected 8", i, lat);
      end
      checks++;
      if ({res32, co32, ov32, zr32} !== {v[i].res, v[i].co, v[i].ov, v[i].z}) begin
        errors++;
        $display("FAIL op[%0d] %b: got res=%h co=%b ov=%b z=%b expected res=%h co=%b ov=%b z=%b",
                 i, v[i].op, res32, co32, ov32, zr32, v[i].res, v[i].co, v[i].ov, v[i].z);
      end
      release32();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start32(3'b101, 32'h1234_5678, 32'h1111_1111);
    wait32(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sv32 = ~sv32; a32 = $urandom; b32 = $urandom; op32 = 3'(i);
      @(posedge clk);
      #1;
      checks++;
      if ({rv32, sr32, res32, co32, ov32, zr32} !== {1'b1, 1'b0, 32'h2345_6789, 3'b000}) begin
        errors++;
        $display("FAIL hold[%0d]: got rv=%b sr=%b res=%h co=%b ov=%b z=%b expected rv=1 sr=0 res=23456789 co=0 ov=0 z=0",
                 i, rv32, sr32, res32, co32, ov32, zr32);
      end
    end
    sv32 = 0;
    release32();
    checks++;
    if ({sr32, rv32} !== 2'b10) begin
      errors++;
      $display("FAIL handshake: got sr=%b rv=%b expected sr=1 rv=0", sr32, rv32);
    end
    start32(3'b100, 32'h0000_000A, 32'h0000_0003);
    wait32(lat);
    checks++;
    if ({lat == 8, res32, co32, ov32, zr32} !== {1'b1, 32'h0000_0007, 3'b100}) begin
      errors++;
      $display("FAIL b2b_sub: got lat=%0d res=%h co=%b ov=%b z=%b expected lat=8 res=00000007 co=1 ov=0 z=0",
               lat, res32, co32, ov32, zr32);
    end
    release32();
  endtask

  task automatic test_async_reset();
    int lat;
    start32(3'b101, 32'h1111_1111, 32'h2222_2222);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    checks++;
    if ({sr32, rv32, res32, co32, ov32, zr32} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      errors++;
      $display("FAIL async_reset: got sr=%b rv=%b res=%h co=%b ov=%b z=%b expected sr=1 rv=0 res=0 co=0 ov=0 z=0",
               sr32, rv32, res32, co32, ov32, zr32);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({sr32, rv32} !== 2'b10) begin
      errors++;
      $display("FAIL abort_idle: got sr=%b rv=%b expected sr=1 rv=0", sr32, rv32);
    end
    start32(3'b101, 32'd3, 32'd4);
    wait32(lat);
    checks++;
    if ({lat == 8, res32, co32, ov32, zr32} !== {1'b1, 32'd7, 3'b000}) begin
      errors++;
      $display("FAIL post_reset_add: got lat=%0d res=%h co=%b ov=%b z=%b expected lat=8 res=00000007 co=0 ov=0 z=0",
               lat, res32, co32, ov32, zr32);
    end
    release32();
  endtask

  task automatic test_width8();
    logic [2:0] ops [2] = '{3'b101, 3'b100};
    logic [7:0] as  [2] = '{8'hFF, 8'h80};
    logic [7:0] bs  [2] = '{8'h01, 8'h01};
    logic [7:0] er  [2] = '{8'h00, 8'h7F};
    logic [2:0] ef  [2] = '{3'b101, 3'b110};
    for (int i = 0; i < 2; i++) begin
      int lat;
      @(negedge clk);
      sv8 = 1; op8 = ops[i]; a8 = as[i]; b8 = bs[i];
      @(posedge clk);
      #1;
      sv8 = 0; a8 = 8'h33; b8 = 8'h44; op8 = 3'b000;
      lat = 0;
      while (!rv8 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks++;
      if ({lat == 2, res8, co8, ov8, zr8} !== {1'b1, er[i], ef[i]}) begin
        errors++;
        $display("FAIL width8[%0d]: got lat=%0d res=%h co=%b ov=%b z=%b expected lat=2 res=%h co/ov/z=%b",
                 i, lat, res8, co8, ov8, zr8, er[i], ef[i]);
      end
      @(negedge clk);
      rr8 = 1;
      @(posedge clk);
      #1;
      rr8 = 0;
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_back_to_back();
    test_async_reset();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
